// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// TXDATA stores are queued in a small FIFO; STATUS/DIV reads are combinational.
module mmio_uart_tx #(
  parameter logic [31:0] BASE      = 32'h0000_0100,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [15:0]     div, baud, eff_m1;
  logic [7:0]      shift, shift_nxt;
  logic [2:0]      idx, idx_nxt;
  logic            tx_nxt;
  logic [1:0]      off;
  logic            empty, full, busy, bit_end;
  logic            push_req, push, pop, ovf_set, ovf_clr, div_we, load_bit;
  logic [3:0]      count4;
  logic            unused_bits;

  assign hit         = (a[31:4] == BASE[31:4]);
  assign off         = a[3:2];
  assign unused_bits = ^{wd[31:16], a[1:0]};

  assign push_req = we && hit && (off == 2'd0);
  assign ovf_clr  = we && hit && (off == 2'd1) && wd[3];
  assign div_we   = we && hit && (off == 2'd2);

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign busy    = (state != IDLE);
  assign bit_end = (baud == 16'd0);
  assign eff_m1  = (div == 16'd0) ? 16'd0 : div - 16'd1;
  assign count4  = 4'(count);

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  always_comb begin
    rd = 32'd0;
    if (hit) begin
      case (off)
        2'd1:    rd = {24'd0, count4, ovf, busy, full, empty};
        2'd2:    rd = {16'd0, div};
        default: rd = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_bit  = 1'b0;
    case (state)
      IDLE:  if (!empty) begin pop = 1'b1; load_bit = 1'b1; state_nxt = START; end
      START: if (bit_end) begin load_bit = 1'b1; state_nxt = DATA; end
      DATA:  if (bit_end) begin
               load_bit = 1'b1;
               if (idx == 3'd7) state_nxt = STOP;
             end
      STOP:  if (bit_end) begin
               if (!empty) begin pop = 1'b1; load_bit = 1'b1; state_nxt = START; end
               else state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_nxt    = tx;
    shift_nxt = shift;
    idx_nxt   = idx;
    case (state)
      IDLE, STOP: if (pop) begin shift_nxt = mem[rptr]; tx_nxt = 1'b0; end
      START: if (bit_end) begin tx_nxt = shift[0]; idx_nxt = 3'd0; end
      DATA:  if (bit_end) begin
               if (idx == 3'd7) tx_nxt = 1'b1;
               else begin
                 tx_nxt    = shift[1];
                 shift_nxt = shift >> 1;
                 idx_nxt   = idx + 3'd1;
               end
             end
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx    <= 1'b1;
      shift <= 8'd0;
      idx   <= 3'd0;
      baud  <= 16'd0;
    end else begin
      tx    <= tx_nxt;
      shift <= shift_nxt;
      idx   <= idx_nxt;
      if (load_bit)                        baud <= eff_m1;
      else if (busy && baud != 16'd0)      baud <= baud - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      div   <= DIV_RESET;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (div_we) div <= wd[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wd[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO and reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a, wd, rd;
  logic        hit, tx;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  logic hist [0:4095];

  mmio_uart_tx dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd),
    .rd(rd), .hit(hit), .tx(tx)
  );

  always #5 clk = ~clk;

  // tx value observed just after edge number cyc
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 hist[cyc & 4095] = tx;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, output int e);
    @(negedge clk);
    we = 1'b1; a = addr; wd = data;
    @(posedge clk);
    #2;
    e  = cyc;
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] d);
    @(negedge clk);
    we = 1'b0; a = addr;
    #1 d = rd;
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Expected line level k cycles (1-based) after the edge that launched a frame.
  function automatic logic frame_bit(input int k, input int eff, input logic [7:0] b);
    int bn;
    bn = (k - 1) / eff;
    if (bn == 0) return 1'b0;
    if (bn >= 9) return 1'b1;
    return b[bn-1];
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    int e;
    reset = 1'b1; we = 1'b0; a = 32'd0; wd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    @(negedge clk) reset = 1'b0;
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL reset_status: got %h want 00000001", d); else n_pass++;
    bus_rd(BASE + 8, d);
    n_total++;
    if (d !== 32'd868) $display("FAIL reset_div: got %0d want 868", d); else n_pass++;
    n_total++;
    if (hit !== 1'b1) $display("FAIL hit_in_window: got %b want 1", hit); else n_pass++;
    bus_rd(BASE + 32'h10, d);
    n_total++;
    if (hit !== 1'b0 || d !== 32'd0) $display("FAIL hit_outside: hit %b rd %h want 0/0", hit, d); else n_pass++;
    bus_wr(32'h0000_0208, 32'd5, e);
    bus_rd(BASE + 8, d);
    n_total++;
    if (d !== 32'd868) $display("FAIL miss_write_div: got %0d want 868", d); else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    int e, n;
    bus_wr(BASE + 8, 32'd4, e);
    bus_rd(BASE + 8, d);
    n_total++;
    if (d !== 32'd4) $display("FAIL div_readback: got %0d want 4", d); else n_pass++;
    bus_wr(BASE, 32'hFFFF_FFA5, n);
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h10) $display("FAIL status_after_push: got %h want 00000010", d); else n_pass++;
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h5) $display("FAIL status_busy: got %h want 00000005", d); else n_pass++;
    wait_edge(n + 44);
    n_total++;
    if (hist[n & 4095] !== 1'b1) $display("FAIL a5_pre_idle: got %b want 1", hist[n & 4095]); else n_pass++;
    for (int k = 1; k <= 40; k++) begin
      n_total++;
      if (hist[(n + k) & 4095] !== frame_bit(k, 4, 8'hA5))
        $display("FAIL a5_frame cycle %0d: got %b want %b", k, hist[(n + k) & 4095], frame_bit(k, 4, 8'hA5));
      else n_pass++;
    end
    n_total++;
    if (hist[(n + 41) & 4095] !== 1'b1) $display("FAIL a5_post_idle: got %b want 1", hist[(n + 41) & 4095]); else n_pass++;
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL a5_status_done: got %h want 00000001", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  b;
    int e, n;
    bus_wr(BASE + 8, 32'd2, e);
    bus_wr(BASE, 32'h01, n);
    for (int i = 2; i <= 5; i++) bus_wr(BASE, i, e);
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h46) $display("FAIL b2b_full_status: got %h want 00000046", d); else n_pass++;
    wait_edge(n + 104);
    for (int f = 0; f < 5; f++) begin
      b = 8'(f + 1);
      for (int k = 1; k <= 20; k++) begin
        n_total++;
        if (hist[(n + 20*f + k) & 4095] !== frame_bit(k, 2, b))
          $display("FAIL b2b_frame %0d cycle %0d: got %b want %b", f, k, hist[(n + 20*f + k) & 4095], frame_bit(k, 2, b));
        else n_pass++;
      end
    end
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL b2b_status_done: got %h want 00000001", d); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  exp_b [6];
    int e, n;
    exp_b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h77};
    bus_wr(BASE, 32'h11, n);
    for (int i = 1; i < 5; i++) bus_wr(BASE, 32'h11 + i, e);
    bus_wr(BASE, 32'h66, e);
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h4E) $display("FAIL ovf_set: got %h want 0000004e", d); else n_pass++;
    bus_wr(BASE + 4, 32'h8, e);
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h46) $display("FAIL ovf_clear: got %h want 00000046", d); else n_pass++;
    // lands on the edge where the first stop bit ends and the next byte is popped
    wait_edge(n + 20);
    bus_wr(BASE, 32'h77, e);
    n_total++;
    if (e !== n + 21) $display("FAIL push_pop_edge: wrote on edge %0d want %0d", e, n + 21); else n_pass++;
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h46) $display("FAIL push_pop_full: got %h want 00000046", d); else n_pass++;
    wait_edge(n + 145);
    for (int f = 0; f < 6; f++) begin
      for (int k = 1; k <= 20; k++) begin
        n_total++;
        if (hist[(n + 20*f + k) & 4095] !== frame_bit(k, 2, exp_b[f]))
          $display("FAIL ovf_frame %0d cycle %0d: got %b want %b", f, k, hist[(n + 20*f + k) & 4095], frame_bit(k, 2, exp_b[f]));
        else n_pass++;
      end
    end
    for (int k = 121; k <= 140; k++) begin
      n_total++;
      if (hist[(n + k) & 4095] !== 1'b1) $display("FAIL ovf_tail_idle cycle %0d: got %b want 1", k, hist[(n + k) & 4095]); else n_pass++;
    end
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL ovf_status_done: got %h want 00000001", d); else n_pass++;
  endtask

  task automatic test_div_zero();
    logic [31:0] d;
    int e, n;
    bus_wr(BASE + 8, 32'h0, e);
    bus_rd(BASE + 8, d);
    n_total++;
    if (d !== 32'd0) $display("FAIL div0_readback: got %0d want 0", d); else n_pass++;
    bus_wr(BASE, 32'hFF, n);
    wait_edge(n + 14);
    for (int k = 1; k <= 11; k++) begin
      n_total++;
      if (hist[(n + k) & 4095] !== frame_bit(k, 1, 8'hFF))
        $display("FAIL div0_frame cycle %0d: got %b want %b", k, hist[(n + k) & 4095], frame_bit(k, 1, 8'hFF));
      else n_pass++;
    end
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL div0_status_done: got %h want 00000001", d); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int e, n, r, zeros;
    bus_wr(BASE + 8, 32'd4, e);
    bus_wr(BASE, 32'h00, n);
    bus_wr(BASE, 32'h3C, e);
    bus_wr(BASE, 32'h5A, e);
    wait_edge(n + 13);
    n_total++;
    if (tx !== 1'b0) $display("FAIL midframe_tx_low: got %b want 0", tx); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++;
    if (tx !== 1'b1) $display("FAIL reset_async_tx: got %b want 1", tx); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_rd(BASE + 4, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL midreset_status: got %h want 00000001", d); else n_pass++;
    bus_rd(BASE + 8, d);
    n_total++;
    if (d !== 32'd868) $display("FAIL midreset_div: got %0d want 868", d); else n_pass++;
    r = cyc;
    wait_edge(r + 60);
    zeros = 0;
    for (int k = 1; k <= 60; k++) if (hist[(r + k) & 4095] !== 1'b1) zeros++;
    n_total++;
    if (zeros !== 0) $display("FAIL midreset_no_frame: got %0d low cycles want 0", zeros); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_div_zero();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
